// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: aligns stores, extends loads, and stalls the
// pipeline through a busywait handshake with a multi-cycle word-wide data memory.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IN_ADDRESS,
    input  logic [31:0] IN_WRITE_DATA,
    input  logic [3:0]  IN_READ_WRITE,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic        BUSYWAIT,
    output logic [31:0] OUT_LOAD_DATA,
    output logic        OUT_MISALIGNED,
    output logic        OUT_MEM_ERROR,
    output logic [29:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic [7:0]  r_count;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_is_load;
    logic [31:0] r_load_data;
    logic        r_mem_error;
    logic [29:0] r_mem_address;
    logic [31:0] r_mem_writedata;
    logic [3:0]  r_mem_byte_en;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_size;
    logic        w_unsigned;
    logic        w_misaligned;
    logic        w_start;
    logic [31:0] w_store_data;
    logic [3:0]  w_byte_en;
    logic [7:0]  w_byte_sel;
    logic [15:0] w_half_sel;
    logic [31:0] w_load_ext;
    logic [8:0]  w_count_inc;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = SZ_B;
        w_unsigned = 1'b0;
        case (IN_READ_WRITE)
            4'b1000: begin w_is_load = 1'b1;  w_size = SZ_B; end
            4'b1001: begin w_is_load = 1'b1;  w_size = SZ_H; end
            4'b1010: begin w_is_load = 1'b1;  w_size = SZ_W; end
            4'b1100: begin w_is_load = 1'b1;  w_size = SZ_B; w_unsigned = 1'b1; end
            4'b1101: begin w_is_load = 1'b1;  w_size = SZ_H; w_unsigned = 1'b1; end
            4'b0101: begin w_is_store = 1'b1; w_size = SZ_B; end
            4'b0110: begin w_is_store = 1'b1; w_size = SZ_H; end
            4'b0111: begin w_is_store = 1'b1; w_size = SZ_W; end
            default: ;
        endcase
    end

    assign w_misaligned = ((w_size == SZ_H) && IN_ADDRESS[0]) ||
                          ((w_size == SZ_W) && (IN_ADDRESS[1:0] != 2'b00));
    assign w_start = (r_state == S_IDLE) && (w_is_load || w_is_store) && !w_misaligned;

    // Stall is raised combinationally so the pipeline freezes in the cycle the op arrives.
    assign BUSYWAIT       = !RESET && (w_start || (r_state == S_ACCESS));
    assign OUT_MISALIGNED = !RESET && (r_state == S_IDLE) && (w_is_load || w_is_store) && w_misaligned;

    always_comb begin
        w_store_data = IN_WRITE_DATA;
        w_byte_en    = 4'b1111;
        if (w_is_store) begin
            case (w_size)
                SZ_B: begin
                    w_store_data = {4{IN_WRITE_DATA[7:0]}};
                    w_byte_en    = 4'b0001 << IN_ADDRESS[1:0];
                end
                SZ_H: begin
                    w_store_data = {2{IN_WRITE_DATA[15:0]}};
                    w_byte_en    = 4'b0011 << IN_ADDRESS[1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_lane)
            2'd0:    w_byte_sel = MEM_READDATA[7:0];
            2'd1:    w_byte_sel = MEM_READDATA[15:8];
            2'd2:    w_byte_sel = MEM_READDATA[23:16];
            default: w_byte_sel = MEM_READDATA[31:24];
        endcase
        w_half_sel = r_lane[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
        case (r_size)
            SZ_B:    w_load_ext = {{24{w_byte_sel[7] & !r_unsigned}}, w_byte_sel};
            SZ_H:    w_load_ext = {{16{w_half_sel[15] & !r_unsigned}}, w_half_sel};
            default: w_load_ext = MEM_READDATA;
        endcase
    end

    assign w_count_inc = {1'b0, r_count} + 9'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state         <= S_IDLE;
            r_count         <= 8'd0;
            r_lane          <= 2'd0;
            r_size          <= SZ_B;
            r_unsigned      <= 1'b0;
            r_is_load       <= 1'b0;
            r_load_data     <= 32'd0;
            r_mem_error     <= 1'b0;
            r_mem_address   <= 30'd0;
            r_mem_writedata <= 32'd0;
            r_mem_byte_en   <= 4'd0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mem_address   <= IN_ADDRESS[31:2];
                        r_mem_writedata <= w_store_data;
                        r_mem_byte_en   <= w_byte_en;
                        r_mem_read      <= w_is_load;
                        r_mem_write     <= w_is_store;
                        r_count         <= 8'd0;
                        r_lane          <= IN_ADDRESS[1:0];
                        r_size          <= w_size;
                        r_unsigned      <= w_unsigned;
                        r_is_load       <= w_is_load;
                        r_state         <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Completion wins over timeout when both land on the same edge.
                    if (!MEM_BUSYWAIT) begin
                        if (r_is_load) begin
                            r_load_data <= w_load_ext;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= S_DONE;
                    end else if (w_count_inc >= TIMEOUT_LIMIT) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_load_data <= 32'd0;
                        r_mem_error <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_count <= w_count_inc[7:0];
                    end
                end
                S_DONE: begin
                    r_mem_error <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign OUT_LOAD_DATA = r_load_data;
    assign OUT_MEM_ERROR = r_mem_error;
    assign MEM_ADDRESS   = r_mem_address;
    assign MEM_WRITEDATA = r_mem_writedata;
    assign MEM_BYTE_EN   = r_mem_byte_en;
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit. Sits directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs: OUT_ALU_RESULT is the byte address, OUT_DATA2 is the store data, OUT_READ_WRITE is the memory op.
- Drives a word-wide, multi-cycle data memory through a busywait handshake. Performs byte-lane alignment, byte enables and load sign/zero extension.
- Generates the pipeline-wide BUSYWAIT stall that freezes the EX/MEM register (and earlier stages) until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, max ACCESS cycles with MEM_BUSYWAIT high before the access is aborted (range 1..255)

Ports:
CLK  input  1  clock, rising-edge
RESET  input  1  reset, asynchronous, active-high
IN_ADDRESS  input  32  byte address (from EX/MEM OUT_ALU_RESULT)
IN_WRITE_DATA  input  32  store data (from EX/MEM OUT_DATA2)
IN_READ_WRITE  input  4  memory op code (from EX/MEM OUT_READ_WRITE)
MEM_READDATA  input  32  word read from data memory
MEM_BUSYWAIT  input  1  data memory busy; low = access complete this cycle
BUSYWAIT  output  1  stall to all pipeline registers
OUT_LOAD_DATA  output  32  extended load result to MEM/WB
OUT_MISALIGNED  output  1  misaligned access flag
OUT_MEM_ERROR  output  1  access timed out
MEM_ADDRESS  output  30  word address (IN_ADDRESS[31:2])
MEM_WRITEDATA  output  32  lane-shifted store data
MEM_BYTE_EN  output  4  byte enables, bit i = byte lane i
MEM_READ  output  1  read strobe
MEM_WRITE  output  1  write strobe

Behaviour:
- Op codes:
  - Loads: 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU.
  - Stores: 0101 SB, 0110 SH, 0111 SW.
  - Every other code is a no-op.
- Alignment: lane = IN_ADDRESS[1:0].
  - H ops need IN_ADDRESS[0]=0.
  - W ops need IN_ADDRESS[1:0]=00.
  - A misaligned op issues no memory access and keeps BUSYWAIT=0. OUT_MISALIGNED=1 combinationally while the op is presented in IDLE.
- Store lanes:
  - SB: data byte replicated to all 4 lanes, BYTE_EN = 0001<<lane.
  - SH: data halfword replicated to both halves, BYTE_EN = 0011<<lane.
  - SW: BYTE_EN = 1111.
  - Loads: BYTE_EN = 1111.
- Load extract: selected byte/half taken from lane. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on a valid aligned op, BUSYWAIT=1 combinationally in the same cycle. Next edge: register MEM_ADDRESS/WRITEDATA/BYTE_EN, set MEM_READ or MEM_WRITE, clear the timeout counter, go to ACCESS.
  - ACCESS: BUSYWAIT=1 and strobes held stable.
    - Edge with MEM_BUSYWAIT=0: latch extended load data into OUT_LOAD_DATA (stores leave it unchanged), drop strobes, go to DONE.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES: drop strobes, OUT_LOAD_DATA=0, OUT_MEM_ERROR=1, go to DONE.
  - DONE: BUSYWAIT=0 for exactly one cycle. The pipeline advances at this edge. Go to IDLE unconditionally. OUT_MEM_ERROR clears on leaving DONE.
- Latency:
  - Op presented in cycle n with a zero-wait memory: BUSYWAIT high in cycles n and n+1, low in cycle n+2 with OUT_LOAD_DATA valid.
  - Each extra memory wait cycle adds one cycle.
- The DONE→IDLE transition ignores inputs. If the pipeline is held by another stall source, the same op re-executes; this is harmless (loads idempotent, stores rewrite the same value).
- OUT_LOAD_DATA holds its value until the next completed load.
- Reset (asynchronous, any state, including mid-ACCESS):
  - State goes to IDLE.
  - MEM_READ=0, MEM_WRITE=0, MEM_BYTE_EN=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - OUT_LOAD_DATA=0, OUT_MEM_ERROR=0, counter=0.
  - BUSYWAIT=0 and OUT_MISALIGNED=0 while RESET is high.
- MEM_READ and MEM_WRITE are never both high.

Test Plan:
- Reset: assert RESET mid-ACCESS (MEM_BUSYWAIT held high) -> all outputs 0 asynchronously, state IDLE, strobes low before the next edge.
- LB at 0x00000103 with MEM_READDATA=0x80FF7F01, zero-wait -> MEM_ADDRESS=0x40, BUSYWAIT high 2 cycles, OUT_LOAD_DATA=0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH at 0x00000012, data 0x0000BEEF, memory busy 3 cycles -> MEM_WRITE=1, MEM_BYTE_EN=1100, MEM_WRITEDATA=0xBEEFBEEF, BUSYWAIT high 5 cycles then low 1 cycle.
- LW at 0x00000006 -> OUT_MISALIGNED=1, BUSYWAIT=0, MEM_READ never asserted. LH at 0x00000006 with 0x1234ABCD -> OUT_LOAD_DATA=0x00001234.
- TIMEOUT_CYCLES=4, SW with MEM_BUSYWAIT stuck high -> strobes drop after 4 ACCESS cycles, OUT_MEM_ERROR=1 and BUSYWAIT=0 for one cycle, then IDLE.
- Back-to-back: LW 0x20 then SW 0x24 -> second access starts the cycle after DONE. No overlap of MEM_READ/MEM_WRITE.
